gate_input_debouncer: RTL and testbench

- Two-channel input conditioning stage that sits directly upstream of the two-input logic gates (OR/AND) in the design.
- Takes raw, asynchronous, bouncy switch/button levels and synchronises each one into the clock domain.
- Filters each channel so an output changes only after the input has held a new level for STABLE_CYCLES consecutive clocks.
- Drives clean levels a_db/b_db into the gate inputs a/b, plus single-cycle edge pulses for counters and monitors.

---
 rtl/gate_input_debouncer.sv | 116 +++++++++++
 tb/tb_gate_input_debouncer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/gate_input_debouncer.sv
// Two-channel synchroniser + debouncer feeding the OR/AND gate inputs.
// Each channel flips its clean level after STABLE_CYCLES consecutive mismatching samples.
module gate_input_debouncer #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic a_raw,
    input  logic b_raw,
    output logic a_db,
    output logic b_db,
    output logic a_rise,
    output logic a_fall,
    output logic b_rise,
    output logic b_fall
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES);
    localparam int unsigned NCH   = 2;

    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } state_t;

    logic [NCH-1:0] raw_v;
    logic [NCH-1:0] db_v;
    logic [NCH-1:0] rise_v;
    logic [NCH-1:0] fall_v;

    assign raw_v = {b_raw, a_raw};

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic             s1;
        logic             s;
        logic             db;
        logic             rise;
        logic             fall;
        logic [CNT_W-1:0] cnt;
        state_t           state;

        logic             db_nxt;
        logic             rise_nxt;
        logic             fall_nxt;
        logic [CNT_W-1:0] cnt_nxt;
        state_t           state_nxt;

        // Synchroniser, FSM state, counter and registered outputs.
        always_ff @(posedge clk) begin
            if (rst) begin
                s1    <= 1'b0;
                s     <= 1'b0;
                state <= STABLE;
                cnt   <= '0;
                db    <= 1'b0;
                rise  <= 1'b0;
                fall  <= 1'b0;
            end else begin
                s1    <= raw_v[i];
                s     <= s1;
                state <= state_nxt;
                cnt   <= cnt_nxt;
                db    <= db_nxt;
                rise  <= rise_nxt;
                fall  <= fall_nxt;
            end
        end

        // Next-state: count consecutive mismatches, restart on any bounce back.
        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            db_nxt    = db;
            rise_nxt  = 1'b0;
            fall_nxt  = 1'b0;
            case (state)
                STABLE: begin
                    if (s != db) begin
                        state_nxt = PENDING;
                        cnt_nxt   = CNT_W'(1);
                    end
                end
                PENDING: begin
                    if (s == db) begin
                        state_nxt = STABLE;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_W'(STABLE_CYCLES - 1)) begin
                        state_nxt = STABLE;
                        cnt_nxt   = '0;
                        db_nxt    = s;
                        rise_nxt  = s;
                        fall_nxt  = ~s;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt = STABLE;
                    cnt_nxt   = '0;
                end
            endcase
        end

        assign db_v[i]   = db;
        assign rise_v[i] = rise;
        assign fall_v[i] = fall;
    end

    assign a_db   = db_v[0];
    assign b_db   = db_v[1];
    assign a_rise = rise_v[0];
    assign a_fall = fall_v[0];
    assign b_rise = rise_v[1];
    assign b_fall = fall_v[1];

endmodule

// File: tb/tb_gate_input_debouncer.sv
// Randomised + directed bench for gate_input_debouncer against a sample-window model.
module tb_gate_input_debouncer;

    localparam int unsigned N = 4;

    logic clk;
    logic rst;
    logic a_raw;
    logic b_raw;
    logic a_db;
    logic b_db;
    logic a_rise;
    logic a_fall;
    logic b_rise;
    logic b_fall;

    int n_pass;
    int n_total;

    // Model: raw is seen two edges late; db flips once the last N samples all disagree with it.
    logic m_s1   [2];
    logic m_s    [2];
    logic m_db   [2];
    logic m_rise [2];
    logic m_fall [2];
    logic hist   [2][N];
    int   hist_len [2];

    gate_input_debouncer #(.STABLE_CYCLES(N)) dut (
        .clk    (clk),
        .rst    (rst),
        .a_raw  (a_raw),
        .b_raw  (b_raw),
        .a_db   (a_db),
        .b_db   (b_db),
        .a_rise (a_rise),
        .a_fall (a_fall),
        .b_rise (b_rise),
        .b_fall (b_fall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    task automatic model_edge(input logic r, input logic [1:0] raw);
        for (int c = 0; c < 2; c++) begin
            if (r) begin
                m_s1[c] = 1'b0; m_s[c] = 1'b0; m_db[c] = 1'b0;
                m_rise[c] = 1'b0; m_fall[c] = 1'b0; hist_len[c] = 0;
            end else begin
                logic s_pre;
                logic all_diff;
                s_pre   = m_s[c];
                m_s[c]  = m_s1[c];
                m_s1[c] = raw[c];
                for (int j = N - 1; j > 0; j--) hist[c][j] = hist[c][j-1];
                hist[c][0] = s_pre;
                if (hist_len[c] < N) hist_len[c]++;
                m_rise[c] = 1'b0;
                m_fall[c] = 1'b0;
                all_diff  = (hist_len[c] == N);
                for (int j = 0; j < N; j++)
                    if (hist[c][j] == m_db[c]) all_diff = 1'b0;
                if (all_diff) begin
                    m_rise[c]   = ~m_db[c];
                    m_fall[c]   = m_db[c];
                    m_db[c]     = ~m_db[c];
                    hist_len[c] = 0;
                end
            end
        end
    endtask

    function automatic logic [5:0] outs();
        return {a_db, a_rise, a_fall, b_db, b_rise, b_fall};
    endfunction

    function automatic logic [5:0] model_outs();
        return {m_db[0], m_rise[0], m_fall[0], m_db[1], m_rise[1], m_fall[1]};
    endfunction

    // One clock: apply inputs, advance model at the edge, compare just after it.
    task automatic step(input logic a, input logic b, input logic r);
        a_raw = a;
        b_raw = b;
        rst   = r;
        @(posedge clk);
        model_edge(r, {b, a});
        #1;
        check("outs", 16'(outs()), 16'(model_outs()));
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        int rise_at;
        int fall_at;
        int b_rise_at;
        int cnt;
        int or_low;
        logic ra, rb;
        int hold_a, hold_b;

        clk = 1'b0; rst = 1'b1; a_raw = 1'b0; b_raw = 1'b0;
        n_pass = 0; n_total = 0;
        for (int c = 0; c < 2; c++) begin
            m_s1[c] = 1'b0; m_s[c] = 1'b0; m_db[c] = 1'b0;
            m_rise[c] = 1'b0; m_fall[c] = 1'b0; hist_len[c] = 0;
            for (int j = 0; j < N; j++) hist[c][j] = 1'b0;
        end

        // Reset state and clean rise
        do_reset();
        check("reset_outs", 16'(outs()), 16'h0);
        rise_at = -1; cnt = 0;
        for (int e = 0; e < 12; e++) begin
            step(1'b1, 1'b0, 1'b0);
            if (a_rise) begin cnt++; if (rise_at < 0) rise_at = e; end
        end
        check("clean_rise_edge", 16'(rise_at), 16'(N + 1));
        check("clean_rise_count", 16'(cnt), 16'd1);

        // Falling edge from a_db=1
        fall_at = -1; cnt = 0;
        for (int e = 0; e < 12; e++) begin
            step(1'b0, 1'b0, 1'b0);
            if (a_fall) begin if (fall_at < 0) fall_at = e; end
            if (a_rise) cnt++;
        end
        check("fall_edge", 16'(fall_at), 16'(N + 1));
        check("fall_no_rise", 16'(cnt), 16'd0);

        // Bounce rejection: 3 high, 1 low, then held high
        do_reset();
        cnt = 0;
        for (int e = 0; e < 20; e++) begin
            step((e == 3) ? 1'b0 : 1'b1, 1'b0, 1'b0);
            if (a_rise) cnt++;
            if (e == 6) check("bounce_hold_low", 16'(a_db), 16'd0);
        end
        check("bounce_rise_count", 16'(cnt), 16'd1);
        check("bounce_final_db", 16'(a_db), 16'd1);

        // Dual-channel independence with a single bounce on B
        do_reset();
        rise_at = -1; b_rise_at = -1; or_low = 0;
        for (int e = 0; e < 20; e++) begin
            step(1'b1, (e == 2) ? 1'b0 : 1'b1, 1'b0);
            if (a_rise && rise_at < 0) rise_at = e;
            if (b_rise && b_rise_at < 0) b_rise_at = e;
            if (e >= N + 1 && !(a_db | b_db)) or_low++;
        end
        check("dual_a_rise_edge", 16'(rise_at), 16'(N + 1));
        check("dual_b_later", 16'(b_rise_at > rise_at), 16'd1);
        check("dual_or_high", 16'(or_low), 16'd0);

        // Reset mid-pending discards the change
        do_reset();
        cnt = 0;
        for (int e = 0; e < 3; e++) begin
            step(1'b1, 1'b0, 1'b0);
            if (a_rise) cnt++;
        end
        step(1'b1, 1'b0, 1'b1);
        check("midreset_no_pulse", 16'(cnt), 16'd0);
        rise_at = -1;
        for (int e = 0; e < 12; e++) begin
            step(1'b1, 1'b0, 1'b0);
            if (a_rise && rise_at < 0) rise_at = e;
        end
        check("midreset_rise_edge", 16'(rise_at), 16'(N + 1));

        // Fast toggle holds outputs
        do_reset();
        cnt = 0;
        for (int e = 0; e < 50; e++) begin
            step(1'(e % 2), 1'b0, 1'b0);
            if (a_db || a_rise || a_fall || b_db || b_rise || b_fall) cnt++;
        end
        check("toggle_quiet", 16'(cnt), 16'd0);

        // Random hold lengths straddling N, occasional reset
        ra = 1'b0; rb = 1'b0; hold_a = 0; hold_b = 0;
        for (int e = 0; e < 3000; e++) begin
            if (hold_a == 0) begin ra = ~ra; hold_a = $urandom_range(1, 2 * N + 2); end
            if (hold_b == 0) begin rb = ~rb; hold_b = $urandom_range(1, 2 * N + 2); end
            hold_a--; hold_b--;
            step(ra, rb, ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
            check("rise_fall_excl", 16'((a_rise & a_fall) | (b_rise & b_fall)), 16'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
